control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Multicycle control sequencer for the Antares-R2 datapath.
- Accepts one opcode per handshake and issues registered microcommands: branch, jump, regDst, memRead, memToReg, memWrite, aluSrc, regWrite, plus link and HI/LO controls.
- Stalls instruction issue during memory accesses and multi-cycle MUL/DIV operations.
- Sits between instruction fetch/decode and the datapath; it supersedes purely combinational opcode decoding.

Parameters:
- MUL_LAT, 4, cycles from md_start to MUL result commit (>=1)
- DIV_LAT, 16, cycles from md_start to DIV result commit (>=1)
- MEM_TIMEOUT, 255, max cycles waiting for mem_ready before abort (>=1)
- CNT_W, 8, width of the shared latency/timeout counter; must hold max(MUL_LAT, DIV_LAT, MEM_TIMEOUT)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- instr_valid  in  1  opcode presented
- opcode  in  6  instruction opcode
- instr_ready  out  1  sequencer can accept an opcode
- mem_ready  in  1  data memory completes the current access
- ctrl_valid  out  1  commit cycle; write enables are meaningful only here
- branch  out  2  01=BEQ, 10=BNE, 00=none
- jump  out  1  PC takes jump target
- link  out  1  write PC+4 to r31
- regDst, aluSrc, memToReg  out  1 each  datapath muxes
- memRead  out  1  held for the whole memory wait
- memWrite, regWrite, hiloWrite  out  1 each  write enables, high only when ctrl_valid=1
- hiRead  out  1  writeback selects HI (MFHI)
- md_start  out  1  one-cycle start pulse to the multiply/divide unit
- md_op  out  1  0=MUL, 1=DIV; valid with md_start
- mem_err  out  1  one-cycle pulse on memory timeout
- illegal  out  1  one-cycle pulse on an undefined opcode

Behaviour:
- Encodings:
  - RTYPE=000000, J=000010, JAL=000011, BEQ=000100, BNE=000101
  - IMM=001xxx, LOAD=100xxx, STORE=101xxx
  - MUL=011100, DIV=011010, MFHI=010000
  - All other codes are illegal.
- Reset:
  - All outputs are 0, including instr_ready.
  - State returns to IDLE and the counter clears, regardless of any operation in progress.
  - instr_ready=1 in the first cycle after reset deasserts.
- Handshake: an opcode is accepted on a rising edge with instr_valid && instr_ready. Outputs are registered; commands appear in the cycle after acceptance.
- States: IDLE, EXEC, MEM, MD.
- IDLE:
  - instr_ready=1.
  - On accept: single-cycle class -> EXEC; LOAD/STORE -> MEM; MUL/DIV -> MD.
  - Illegal opcode: illegal=1 and all other outputs 0 for one cycle; state stays IDLE.
- EXEC (one cycle):
  - ctrl_valid=1 with the class decode.
  - RTYPE: regDst=1, regWrite=1.
  - IMM: aluSrc=1, regWrite=1.
  - BEQ/BNE: aluSrc=1, branch=01/10.
  - J: jump=1.
  - JAL: jump=1, link=1, regWrite=1.
  - MFHI: regDst=1, hiRead=1, regWrite=1.
  - instr_ready=1 in EXEC, so back-to-back issue is allowed; the next accepted opcode goes directly to its next state.
- MEM:
  - instr_ready=0; aluSrc=1; counter loads MEM_TIMEOUT.
  - LOAD: memRead=1 and memToReg=1 held throughout.
  - The first cycle in MEM with mem_ready=1 is the commit cycle:
    - ctrl_valid=1
    - LOAD: regWrite=1
    - STORE: memWrite=1
  - Then -> IDLE with instr_ready=1 on the next cycle.
  - If the counter reaches 0 without mem_ready: mem_err pulse, no write enables, -> IDLE.
  - If mem_ready and timeout coincide, mem_ready wins.
- MD:
  - md_start=1 and md_op set in the first MD cycle only.
  - Counter loads MUL_LAT or DIV_LAT and decrements each cycle.
  - instr_ready=0 throughout.
  - On the cycle the counter equals 1, commit:
    - ctrl_valid=1
    - MUL: regDst=1, regWrite=1
    - DIV: hiloWrite=1
  - Then -> IDLE.
  - Total busy time = LAT cycles after acceptance.
- Other rules:
  - instr_valid is ignored whenever instr_ready=0.
  - mem_ready outside MEM is ignored.
  - Reset asserted in any state overrides everything in that cycle.

Test Plan:
- Reset, then RTYPE (000000) accepted at cycle 0 -> cycle 1: ctrl_valid=1, regDst=1, regWrite=1; instr_ready stays 1; JAL accepted back-to-back at cycle 1 -> cycle 2: jump=1, link=1, regWrite=1.
- LOAD (100011), mem_ready raised 3 cycles after accept -> memRead=memToReg=1 for 3 cycles; regWrite=1 with ctrl_valid only on the mem_ready cycle; instr_ready=0 throughout the wait.
- STORE (101011) with MEM_TIMEOUT=5 and mem_ready never asserted -> mem_err pulses exactly once after 5 MEM cycles; memWrite never 1; instr_ready returns to 1.
- DIV (011010) with DIV_LAT=16 -> md_start=1, md_op=1 in cycle 1; hiloWrite=1 with ctrl_valid in cycle 16; an MFHI held on instr_valid is accepted in cycle 16 and produces hiRead=1, regWrite=1 in cycle 17.
- MUL accepted, reset asserted 2 cycles later -> all outputs 0 during reset, regWrite never 1, instr_ready=1 the first cycle after reset drops.
- Opcode 111111 -> illegal=1 for one cycle, all other outputs 0, instr_ready remains 1; BEQ/BNE -> branch=01/10 with aluSrc=1 and regWrite=0.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer: multicycle opcode-to-microcommand sequencer with memory and mul/div stalls
module control_sequencer #(
    parameter int MUL_LAT     = 4,
    parameter int DIV_LAT     = 16,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_valid,
    input  logic [5:0] opcode,
    output logic       instr_ready,
    input  logic       mem_ready,
    output logic       ctrl_valid,
    output logic [1:0] branch,
    output logic       jump,
    output logic       link,
    output logic       regDst,
    output logic       aluSrc,
    output logic       memToReg,
    output logic       memRead,
    output logic       memWrite,
    output logic       regWrite,
    output logic       hiloWrite,
    output logic       hiRead,
    output logic       md_start,
    output logic       md_op,
    output logic       mem_err,
    output logic       illegal
);
    typedef enum logic [1:0] {IDLE, EXEC, MEM, MD} state_t;
    state_t state, nstate;
    logic [CNT_W-1:0] cnt, ncnt, md_lat;
    logic is_store, n_is_store, is_div, n_is_div, md_commit;
    logic n_ready, n_cv, n_jump, n_link, n_regdst, n_alusrc, n_memtoreg, n_memread;
    logic n_memwrite, n_regwrite, n_hilowrite, n_hiread, n_mdstart, n_mdop, n_memerr, n_illegal;
    logic [1:0] n_branch;
    logic accept, is_r, is_j, is_jal, is_beq, is_bne, is_imm, is_ld, is_st, is_mul, is_dv, is_mfhi, single;

    assign accept  = instr_valid && instr_ready;
    assign is_r    = opcode == 6'b000000;
    assign is_j    = opcode == 6'b000010;
    assign is_jal  = opcode == 6'b000011;
    assign is_beq  = opcode == 6'b000100;
    assign is_bne  = opcode == 6'b000101;
    assign is_imm  = opcode[5:3] == 3'b001;
    assign is_ld   = opcode[5:3] == 3'b100;
    assign is_st   = opcode[5:3] == 3'b101;
    assign is_mul  = opcode == 6'b011100;
    assign is_dv   = opcode == 6'b011010;
    assign is_mfhi = opcode == 6'b010000;
    assign single  = is_r | is_j | is_jal | is_beq | is_bne | is_imm | is_mfhi;
    assign md_lat  = is_dv ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);

    // Next state plus the command word that will be registered for the next cycle
    always_comb begin
        nstate      = IDLE;
        ncnt        = cnt;
        n_is_store  = is_store;
        n_is_div    = is_div;
        md_commit   = 1'b0;
        n_ready     = 1'b0;
        n_cv        = 1'b0;
        n_branch    = 2'b00;
        n_jump      = 1'b0;
        n_link      = 1'b0;
        n_regdst    = 1'b0;
        n_alusrc    = 1'b0;
        n_memtoreg  = 1'b0;
        n_memread   = 1'b0;
        n_memwrite  = 1'b0;
        n_regwrite  = 1'b0;
        n_hilowrite = 1'b0;
        n_hiread    = 1'b0;
        n_mdstart   = 1'b0;
        n_mdop      = 1'b0;
        n_memerr    = 1'b0;
        n_illegal   = 1'b0;
        if (accept) begin
            if (single) begin
                nstate     = EXEC;
                n_cv       = 1'b1;
                n_ready    = 1'b1;
                n_regdst   = is_r | is_mfhi;
                n_alusrc   = is_imm | is_beq | is_bne;
                n_regwrite = is_r | is_imm | is_jal | is_mfhi;
                n_branch   = {is_bne, is_beq};
                n_jump     = is_j | is_jal;
                n_link     = is_jal;
                n_hiread   = is_mfhi;
            end else if (is_ld || is_st) begin
                nstate     = MEM;
                ncnt       = CNT_W'(MEM_TIMEOUT);
                n_is_store = is_st;
                n_alusrc   = 1'b1;
                n_memread  = is_ld;
                n_memtoreg = is_ld;
            end else if (is_mul || is_dv) begin
                n_is_div  = is_dv;
                ncnt      = md_lat;
                n_mdstart = 1'b1;
                n_mdop    = is_dv;
                md_commit = md_lat == CNT_W'(1);
                nstate    = md_commit ? IDLE : MD;
            end else begin
                n_illegal = 1'b1;
                n_ready   = 1'b1;
            end
        end else if (state == MEM) begin
            n_alusrc   = 1'b1;
            n_memread  = !is_store;
            n_memtoreg = !is_store;
            if (mem_ready) begin
                n_cv       = 1'b1;
                n_regwrite = !is_store;
                n_memwrite = is_store;
            end else if (cnt == CNT_W'(1)) begin
                n_memerr   = 1'b1;
                n_alusrc   = 1'b0;
                n_memread  = 1'b0;
                n_memtoreg = 1'b0;
            end else begin
                nstate = MEM;
                ncnt   = cnt - 1'b1;
            end
        end else if (state == MD) begin
            ncnt      = cnt - 1'b1;
            md_commit = cnt == CNT_W'(2);
            nstate    = md_commit ? IDLE : MD;
        end else begin
            n_ready = 1'b1;
        end
        if (md_commit) begin
            n_cv        = 1'b1;
            n_ready     = 1'b1;
            n_regdst    = !n_is_div;
            n_regwrite  = !n_is_div;
            n_hilowrite = n_is_div;
        end
    end

    // Register state, counter and the full command word; reset clears everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            is_store    <= 1'b0;
            is_div      <= 1'b0;
            instr_ready <= 1'b0;
            ctrl_valid  <= 1'b0;
            branch      <= 2'b00;
            jump        <= 1'b0;
            link        <= 1'b0;
            regDst      <= 1'b0;
            aluSrc      <= 1'b0;
            memToReg    <= 1'b0;
            memRead     <= 1'b0;
            memWrite    <= 1'b0;
            regWrite    <= 1'b0;
            hiloWrite   <= 1'b0;
            hiRead      <= 1'b0;
            md_start    <= 1'b0;
            md_op       <= 1'b0;
            mem_err     <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            state       <= nstate;
            cnt         <= ncnt;
            is_store    <= n_is_store;
            is_div      <= n_is_div;
            instr_ready <= n_ready;
            ctrl_valid  <= n_cv;
            branch      <= n_branch;
            jump        <= n_jump;
            link        <= n_link;
            regDst      <= n_regdst;
            aluSrc      <= n_alusrc;
            memToReg    <= n_memtoreg;
            memRead     <= n_memread;
            memWrite    <= n_memwrite;
            regWrite    <= n_regwrite;
            hiloWrite   <= n_hilowrite;
            hiRead      <= n_hiread;
            md_start    <= n_mdstart;
            md_op       <= n_mdop;
            mem_err     <= n_memerr;
            illegal     <= n_illegal;
        end
    end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed bench with a transaction-level expected-output schedule
module tb_control_sequencer;
    localparam int ML = 4, DL = 16, TO = 5;
    localparam logic [17:0] RDY = 18'h20000, CV = 18'h10000, BNE = 18'h08000, BEQ = 18'h04000;
    localparam logic [17:0] JMP = 18'h02000, LNK = 18'h01000, RD = 18'h00800, AS = 18'h00400;
    localparam logic [17:0] M2R = 18'h00200, MR = 18'h00100, MW = 18'h00080, RW = 18'h00040;
    localparam logic [17:0] HW = 18'h00020, HR = 18'h00010, MDS = 18'h00008, MDO = 18'h00004;
    localparam logic [17:0] ERR = 18'h00002, ILL = 18'h00001;

    logic clk = 0, reset = 1, instr_valid = 0, mem_ready = 0;
    logic [5:0] opcode = '0;
    logic instr_ready, ctrl_valid, jump, link, regDst, aluSrc, memToReg, memRead, memWrite;
    logic regWrite, hiloWrite, hiRead, md_start, md_op, mem_err, illegal;
    logic [1:0] branch;
    logic [17:0] dut_vec;
    logic [17:0] exp_v [0:1023];
    bit have [0:1023];
    int cyc = 0, ready_at = 0, errors = 0, checks = 0;
    int n_memread = 0, n_err = 0, n_wr = 0, mds_cyc = 0, hilo_cyc = 0;

    control_sequencer #(.MUL_LAT(ML), .DIV_LAT(DL), .MEM_TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .opcode(opcode),
        .instr_ready(instr_ready), .mem_ready(mem_ready), .ctrl_valid(ctrl_valid),
        .branch(branch), .jump(jump), .link(link), .regDst(regDst), .aluSrc(aluSrc),
        .memToReg(memToReg), .memRead(memRead), .memWrite(memWrite), .regWrite(regWrite),
        .hiloWrite(hiloWrite), .hiRead(hiRead), .md_start(md_start), .md_op(md_op),
        .mem_err(mem_err), .illegal(illegal));

    assign dut_vec = {instr_ready, ctrl_valid, branch, jump, link, regDst, aluSrc, memToReg,
                      memRead, memWrite, regWrite, hiloWrite, hiRead, md_start, md_op, mem_err, illegal};

    always #5 clk = ~clk;

    // Cycle index advances on every active edge
    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle comparison against the expected schedule
    always @(negedge clk) begin
        if (have[cyc]) begin
            checks++;
            if (dut_vec !== exp_v[cyc]) begin
                errors++;
                $display("FAIL cycle_%0d outputs: got %b expected %b", cyc, dut_vec, exp_v[cyc]);
            end
        end
    end

    // Event tallies used by the literal checks
    always @(negedge clk) begin
        if (memRead === 1'b1) n_memread++;
        if (mem_err === 1'b1) n_err++;
        if (memWrite === 1'b1) n_wr++;
        if (md_start === 1'b1) mds_cyc = cyc;
        if (hiloWrite === 1'b1) hilo_cyc = cyc;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic put(input int c, input logic [17:0] v);
        exp_v[c] = v;
        have[c] = 1;
    endtask

    task automatic tick();
        if (!have[cyc + 1]) put(cyc + 1, RDY);
        @(negedge clk);
    endtask

    // Expected outputs for an opcode accepted in cycle t; k = cycle offset of mem_ready (0 = never)
    task automatic predict(input logic [5:0] op, input int t, input int k);
        logic [17:0] base;
        int lat;
        ready_at = t + 1;
        if (op == 6'b000000) put(t + 1, RDY | CV | RD | RW);
        else if (op == 6'b000010) put(t + 1, RDY | CV | JMP);
        else if (op == 6'b000011) put(t + 1, RDY | CV | JMP | LNK | RW);
        else if (op == 6'b000100) put(t + 1, RDY | CV | AS | BEQ);
        else if (op == 6'b000101) put(t + 1, RDY | CV | AS | BNE);
        else if (op[5:3] == 3'b001) put(t + 1, RDY | CV | AS | RW);
        else if (op == 6'b010000) put(t + 1, RDY | CV | RD | HR | RW);
        else if (op[5:4] == 2'b10) begin
            base = AS | (op[3] ? 18'h0 : (MR | M2R));
            if (k > 0 && k <= TO) begin
                for (int i = 1; i <= k; i++) put(t + i, base);
                put(t + k + 1, base | CV | (op[3] ? MW : RW));
                ready_at = t + k + 2;
            end else begin
                for (int i = 1; i <= TO; i++) put(t + i, base);
                put(t + TO + 1, ERR);
                ready_at = t + TO + 2;
            end
        end else if (op == 6'b011100 || op == 6'b011010) begin
            lat = op[1] ? DL : ML;
            for (int i = 2; i < lat; i++) put(t + i, 18'h0);
            put(t + 1, MDS | (op[1] ? MDO : 18'h0));
            put(t + lat, exp_v[t + lat] | RDY | CV | (op[1] ? HW : (RD | RW)));
            if (lat == 1) put(t + 1, MDS | MDO & {18{op[1]}} | RDY | CV | (op[1] ? HW : (RD | RW)));
            ready_at = t + lat;
        end else put(t + 1, RDY | ILL);
    endtask

    // Hold instr_valid until the model says the sequencer is ready, then present mem_ready if asked
    task automatic issue(input logic [5:0] op, input int k);
        int t;
        instr_valid = 1;
        opcode = op;
        while (cyc < ready_at) tick();
        t = cyc;
        predict(op, t, k);
        tick();
        instr_valid = 0;
        if (op[5:4] == 2'b10 && k > 0) begin
            while (cyc < t + k) tick();
            mem_ready = 1;
            tick();
            mem_ready = 0;
        end
    endtask

    task automatic do_reset(input int n);
        int c;
        c = cyc;
        reset = 1;
        for (int i = 1; i <= n; i++) put(c + i, 18'h0);
        put(c + n + 1, RDY);
        for (int i = c + n + 2; i < c + n + 40; i++) have[i] = 0;
        for (int i = 0; i < n; i++) tick();
        reset = 0;
        ready_at = c + n + 1;
    endtask

    initial begin
        do_reset(3);
        issue(6'b000000, 0);
        issue(6'b000011, 0);
        issue(6'b100011, 2);
        tick(); tick();
        chk("load_memread_cycles", n_memread, 3);
        issue(6'b101011, 0);
        while (cyc < ready_at + 1) tick();
        chk("store_timeout_err_pulses", n_err, 1);
        chk("store_timeout_memwrite", n_wr, 0);
        issue(6'b101011, TO);
        issue(6'b100000, 1);
        tick();
        chk("store_coincide_memwrite", n_wr, 1);
        chk("timeout_err_total", n_err, 1);
        mem_ready = 1;
        issue(6'b011010, 0);
        issue(6'b010000, 0);
        mem_ready = 0;
        tick(); tick();
        chk("div_commit_offset", hilo_cyc - mds_cyc, DL - 1);
        issue(6'b011100, 0);
        tick();
        do_reset(2);
        issue(6'b111111, 0);
        issue(6'b000100, 0);
        issue(6'b000101, 0);
        issue(6'b001101, 0);
        issue(6'b000010, 0);
        issue(6'b000001, 0);
        issue(6'b011011, 0);
        issue(6'b011100, 0);
        issue(6'b110000, 0);
        while (cyc < ready_at + 3) tick();
        chk("memwrite_total", n_wr, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
